// File: rtl/uart_pkg.sv
// Shared constants, rx state encoding and baud divider helper for the UART receive path.
// Pure declarations: no latency, no backpressure.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   // Clocks per oversample tick; never below 1 so the tick counter always advances.
   function automatic int calc_div(input int sys_clk_freq, input int baud_rate);
      int d;
      d = sys_clk_freq / (baud_rate * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, first-word-fall-through; rd_data shows the head combinationally, pushes land next edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  push,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic                  do_pop;
   logic                  do_push;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rptr];

   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem[wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a FWFT byte FIFO; a byte is visible one edge after its stop sample.
// No backpressure on the line: a good byte arriving to a full FIFO is dropped and flagged as overrun.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int SYS_CLK_FREQ    = 100000000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       rx_in,
   input  logic                       rd_en,
   input  logic                       clr_err,
   output logic [7:0]                 rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [FIFO_DEPTH_LOG2:0]   count,
   output logic                       frame_err,
   output logic                       overrun
);

   localparam int             DIV       = calc_div(SYS_CLK_FREQ, BAUD_RATE);
   localparam int             TW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
   localparam logic [3:0]     SC_MID    = 4'(MID_SAMPLE);
   localparam logic [3:0]     SC_LAST   = 4'(OVERSAMPLE - 1);

   logic            rx_meta;
   logic            rx_s;
   logic [TW-1:0]   tcnt;
   logic            tick;
   logic            tcnt_clr;

   rx_state_t       state;
   rx_state_t       state_nxt;
   logic [3:0]      sc;
   logic [3:0]      sc_nxt;
   logic [2:0]      bidx;
   logic [2:0]      bidx_nxt;
   logic [7:0]      shift;
   logic [7:0]      shift_nxt;
   logic            push;
   logic            set_fe;
   logic            set_ov;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   // Restarting on the start edge keeps every sample point phase-locked to that edge.
   assign tick = (tcnt == TICK_LAST);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tcnt <= '0;
      end else if (tcnt_clr || tick) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
         sc    <= '0;
         bidx  <= '0;
         shift <= '0;
      end else begin
         state <= state_nxt;
         sc    <= sc_nxt;
         bidx  <= bidx_nxt;
         shift <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sc_nxt    = sc;
      bidx_nxt  = bidx;
      shift_nxt = shift;
      tcnt_clr  = 1'b0;
      push      = 1'b0;
      set_fe    = 1'b0;
      set_ov    = 1'b0;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               sc_nxt    = '0;
               tcnt_clr  = 1'b1;
            end
         end

         START: begin
            if (tick) begin
               if (sc == SC_MID) begin
                  // A line that is high again mid start bit was only a glitch.
                  if (!rx_s) begin
                     state_nxt = DATA;
                     sc_nxt    = '0;
                     bidx_nxt  = '0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  sc_nxt = sc + 1'b1;
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (sc == SC_LAST) begin
                  sc_nxt          = '0;
                  shift_nxt[bidx] = rx_s;
                  if (bidx == 3'd7) begin
                     state_nxt = STOP;
                  end else begin
                     bidx_nxt = bidx + 1'b1;
                  end
               end else begin
                  sc_nxt = sc + 1'b1;
               end
            end
         end

         STOP: begin
            if (tick) begin
               if (sc == SC_LAST) begin
                  sc_nxt = '0;
                  if (rx_s) begin
                     state_nxt = IDLE;
                     if (!full || rd_en) begin
                        push = 1'b1;
                     end else begin
                        set_ov = 1'b1;
                     end
                  end else begin
                     state_nxt = WAIT_HIGH;
                     set_fe    = 1'b1;
                  end
               end else begin
                  sc_nxt = sc + 1'b1;
               end
            end
         end

         WAIT_HIGH: begin
            // Hold off until the line idles so a break is not seen as a train of start bits.
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (set_fe) begin
            frame_err <= 1'b1;
         end else if (clr_err) begin
            frame_err <= 1'b0;
         end
         if (set_ov) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .push     (push),
      .wr_data  (shift),
      .pop      (rd_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .full     (full),
      .count    (count)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, results compared with a byte-queue model of the receiver.
// All inputs change 1 time unit after a rising edge and outputs are sampled there too.
module tb_uart_rx_fifo;

   localparam int SYS   = 1600000;
   localparam int BAUD  = 100000;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;

   logic           clk_in   = 1'b0;
   logic           rst_n_in = 1'b0;
   logic           rx_in    = 1'b1;
   logic           rd_en    = 1'b0;
   logic           clr_err  = 1'b0;
   logic [7:0]     rd_data;
   logic           empty;
   logic           full;
   logic [DL2:0]   count;
   logic           frame_err;
   logic           overrun;

   int             n_cmp = 0;
   int             n_mis = 0;

   byte unsigned   exp_q[$];
   bit             exp_fe = 1'b0;
   bit             exp_ov = 1'b0;
   byte unsigned   last_pop = 8'h00;

   uart_rx_fifo #(
      .SYS_CLK_FREQ    (SYS),
      .BAUD_RATE       (BAUD),
      .FIFO_DEPTH_LOG2 (DL2)
   ) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .rx_in     (rx_in),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Receiver model at frame level: a good stop bit queues the byte if there is room.
   function automatic void model_frame(input byte unsigned d, input bit stop);
      if (!stop) begin
         exp_fe = 1'b1;
      end else if (exp_q.size() < DEPTH) begin
         exp_q.push_back(d);
      end else begin
         exp_ov = 1'b1;
      end
   endfunction

   task automatic check_status(input string tag);
      check_val({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
      check_val({tag, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
      check_val({tag, ".count"}, 32'(count), 32'(exp_q.size()));
      check_val({tag, ".ferr"},  32'(frame_err), 32'(exp_fe));
      check_val({tag, ".ovr"},   32'(overrun),   32'(exp_ov));
      check_val({tag, ".data"},  32'(rd_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      tick_n(n);
   endtask

   // Start bit begins now; the stop bit is sampled 154 cycles later (2-flop sync + mid-bit sampling).
   task automatic send_frame(input byte unsigned d, input bit stop, input bit pop_at_stop, input string tag);
      rx_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick_n(16);
         rx_in = d[i];
      end
      tick_n(16);
      rx_in = stop;
      tick_n(10);
      check_val({tag, ".pre_cnt"}, 32'(count), 32'(exp_q.size()));
      if (pop_at_stop) begin
         rd_en = 1'b1;
      end
      tick_n(1);
      rd_en = 1'b0;
      if (pop_at_stop && exp_q.size() > 0) begin
         last_pop = exp_q.pop_front();
      end
      model_frame(d, stop);
      check_status(tag);
      tick_n(5);
   endtask

   task automatic do_pop(input string tag);
      check_val({tag, ".head"}, 32'(rd_data), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
      rd_en = 1'b1;
      tick_n(1);
      rd_en = 1'b0;
      if (exp_q.size() > 0) begin
         last_pop = exp_q.pop_front();
      end
      check_val({tag, ".cnt"}, 32'(count), 32'(exp_q.size()));
   endtask

   task automatic pulse_clr(input string tag);
      clr_err = 1'b1;
      tick_n(1);
      clr_err = 1'b0;
      exp_fe  = 1'b0;
      exp_ov  = 1'b0;
      check_val({tag, ".ferr"}, 32'(frame_err), 32'(exp_fe));
      check_val({tag, ".ovr"},  32'(overrun),   32'(exp_ov));
   endtask

   initial begin
      // Reset hold with the line toggling.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_in);
         #1;
         rx_in = ~rx_in;
         check_status("reset");
      end
      rx_in    = 1'b1;
      rst_n_in = 1'b1;
      idle(200);
      check_status("post_reset");

      // Single frame, latency checked inside send_frame, then drained.
      send_frame(8'hA5, 1'b1, 1'b0, "a5");
      idle(4);
      do_pop("a5_pop");
      check_status("a5_after");

      // Short low pulse must not produce a byte.
      rx_in = 1'b0;
      tick_n(4);
      idle(40);
      check_status("glitch");

      // Framing error followed by a break, then a good frame.
      send_frame(8'h3C, 1'b0, 1'b0, "ferr");
      tick_n(40);
      idle(20);
      check_status("break");
      send_frame(8'h11, 1'b1, 1'b0, "f11");
      idle(4);
      pulse_clr("ferr_clr");
      do_pop("f11_pop");
      check_val("f11_val", 32'(last_pop), 32'h11);

      // Overflow: 17 frames into a 16-deep FIFO.
      for (int i = 0; i <= 16; i++) begin
         send_frame(8'(i), 1'b1, 1'b0, "ovf");
         idle(4);
      end
      check_val("ovf_full", 32'(full), 32'h1);
      check_val("ovf_flag", 32'(overrun), 32'h1);
      for (int i = 0; i < 16; i++) begin
         do_pop("ovf_pop");
         check_val("ovf_order", 32'(last_pop), 32'(i));
      end
      check_status("ovf_drained");
      pulse_clr("ovf_clr");

      // Full FIFO with a pop on the stop-sample cycle: push must be accepted.
      for (int i = 0; i < 16; i++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, "fill");
         idle(4);
      end
      send_frame(8'h7E, 1'b1, 1'b1, "simul");
      check_val("simul_ovr", 32'(overrun), 32'h0);
      check_val("simul_cnt", 32'(count), 32'd16);
      idle(4);
      while (exp_q.size() > 0) begin
         do_pop("simul_drain");
      end
      check_val("simul_last", 32'(last_pop), 32'h7E);

      // Random traffic with occasional bad stop bits, reads and error clears.
      for (int it = 0; it < 40; it++) begin
         byte unsigned d;
         bit           stop;
         int           npop;
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 7) != 0);
         send_frame(d, stop, 1'b0, "rnd");
         if (!stop) begin
            tick_n($urandom_range(0, 30));
         end
         idle($urandom_range(4, 12));
         npop = $urandom_range(0, 2);
         for (int p = 0; p < npop; p++) begin
            do_pop("rnd_pop");
         end
         if ($urandom_range(0, 5) == 0) begin
            pulse_clr("rnd_clr");
         end
         check_status("rnd_stat");
      end
      while (exp_q.size() > 0) begin
         do_pop("final_drain");
      end
      do_pop("empty_pop");
      check_status("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Simulation- and FPGA-side UART receiver sitting directly downstream of riscv_top's Tx pin, in the same position the host/bench occupies.
- Deserialises 8N1 frames with 16x oversampling and buffers received bytes in a first-word-fall-through FIFO.
- The testbench or a host model drains bytes through rd_en.
- Reports framing errors and overruns as sticky flags.

Parameters:
- SYS_CLK_FREQ, 100000000: clk_in frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2**FIFO_DEPTH_LOG2 bytes.

Ports:
- clk_in  input  1  single system clock; all logic on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line from riscv_top Tx; asynchronous; idle high.
- rd_en  input  1  pop the FIFO head this cycle; ignored when empty.
- clr_err  input  1  one-cycle pulse that clears frame_err and overrun.
- rd_data  output  8  FIFO head byte; valid whenever empty=0.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- count  output  FIFO_DEPTH_LOG2+1  number of bytes held.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a good byte was dropped because the FIFO was full.

Behaviour:
- **Reset** (rst_n_in=0, asynchronous):
  - Both synchroniser flops go to 1. FSM goes to IDLE. All counters go to 0.
  - Outputs: empty=1, full=0, count=0, rd_data=0, frame_err=0, overrun=0.
  - Reset mid-frame discards the partial byte. FIFO contents are lost.
- **Synchroniser and tick:**
  - rx_in passes through a 2-flop synchroniser; rx_s is the synchronised value.
  - DIV = SYS_CLK_FREQ/(BAUD_RATE*16), integer-truncated, minimum 1.
  - The tick counter counts 0..DIV-1 and emits a one-cycle tick on wrap.
  - The tick counter restarts at 0 on the IDLE->START transition so sampling is phase-aligned to the start edge.
- **FSM** (sample counter sc counts ticks 0..15):
  - IDLE: when rx_s=0, go to START with sc=0.
  - START: on the tick where sc=7 (mid start bit), sample rx_s:
    - rx_s=0: go to DATA with sc=0 and bit index=0.
    - rx_s=1: glitch; return to IDLE with nothing recorded.
  - DATA: on every tick where sc=15, sample rx_s into shift[bit index], LSB first. After bit 7, go to STOP.
  - STOP: on the tick where sc=15, sample the stop bit:
    - Stop=1 and FIFO not full (or a pop occurs the same cycle): push the byte, go to IDLE.
    - Stop=1 and FIFO full with no pop: drop the byte, set overrun, go to IDLE.
    - Stop=0: drop the byte, set frame_err, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from being read as repeated start bits.
- **Latency:** a pushed byte appears on rd_data, and empty deasserts, on the clock edge after the stop-bit sample cycle.
- **FIFO:**
  - Circular buffer with FIFO_DEPTH_LOG2-bit read/write pointers that wrap naturally, plus a count register. Full means count = 2**FIFO_DEPTH_LOG2.
  - Pop when empty is a no-op: pointers and count are unchanged.
  - Simultaneous push and pop: both occur and count is unchanged. This includes the full case, where the push is accepted and no overrun is flagged.
  - Simultaneous push and pop when empty: the push occurs and the pop is ignored.
  - rd_data is combinational from the head entry and reads 0 when empty.
- **Sticky flags:**
  - If clr_err and a new error event occur in the same cycle, set wins.
  - Flags do not block reception.

Decomposition:
- Shared package uart_pkg holds:
  - OVERSAMPLE=16 and MID_SAMPLE=7 constants.
  - The rx state enum: IDLE, START, DATA, STOP, WAIT_HIGH.
  - A function computing DIV with a floor of 1.
- Natural sub-module: sync_fifo, parameterised by width and depth log2, providing push, pop, rd_data, empty, full and count.
- The FSM and tick generator stay in uart_rx_fifo.

Test Plan:
All scenarios use SYS_CLK_FREQ=1600000 and BAUD_RATE=100000, so DIV=1 and one bit is 16 clk_in cycles.
1. Reset hold: rst_n_in=0 for 5 cycles with rx_in toggling -> empty=1, count=0, frame_err=0, overrun=0 throughout; no push after release.
2. Single frame 0xA5 (LSB first, stop=1) -> rd_data=0xA5 and empty=0 one cycle after the stop sample; rd_en pulse -> empty=1, count=0.
3. Glitch: rx_in low for 4 cycles then high -> FSM returns to IDLE; count stays 0 and frame_err stays 0.
4. Framing error: frame 0x3C with stop=0, then line held low for 40 cycles, then high, then frame 0x11 -> frame_err=1; only 0x11 is enqueued; clr_err pulse -> frame_err=0.
5. Overflow: send 17 frames 0x00..0x10 with no reads (depth 16) -> full=1, count=16, overrun=1; reading 16 times returns 0x00..0x0F in order, then empty=1.
6. Simultaneous: FIFO full and rd_en asserted on the stop-sample cycle of frame 0x7E -> overrun stays 0; count stays 16; 0x7E is the last byte read.
